// File: rtl/rsi_trade_pkg.sv
// Shared types and sizing for the RSI order manager.
// Sizing, side encodings and FSM states.
package rsi_trade_pkg;

    localparam int NUM_STOCKS = 4;
    localparam int ID_W       = 2;
    localparam int PRICE_W    = 6;
    localparam int COST_W     = PRICE_W + 3;
    localparam int LOT_SIZE   = 4;
    localparam int CASH_W     = 16;
    localparam int POS_W      = 8;
    localparam int MAX_POS    = 32;
    localparam int COOLDOWN   = 8;

    localparam logic SIDE_BUY  = 1'b1;
    localparam logic SIDE_SELL = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ISSUE = 2'd2
    } state_t;

endpackage

// File: rtl/rsi_order_manager_if.sv
// Order bus towards the downstream sink.
// Valid/ready handshake plus order fields.
interface rsi_order_manager_if;
    import rsi_trade_pkg::*;

    logic               order_valid;
    logic               order_ready;
    logic               order_side;
    logic [ID_W-1:0]    order_stock;
    logic [PRICE_W-1:0] order_price;
    logic [POS_W-1:0]   order_qty;

    modport master (
        output order_valid, order_side, order_stock,
        output order_price, order_qty,
        input  order_ready
    );

    modport slave (
        input  order_valid, order_side, order_stock,
        input  order_price, order_qty,
        output order_ready
    );

endinterface

// File: rtl/rsi_cooldown_bank.sv
// Per-stock cooldown down-counters.
// A load reloads one counter; reload beats the decrement.
module rsi_cooldown_bank
    import rsi_trade_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ID_W-1:0]       load_id,
    output logic [NUM_STOCKS-1:0] zero
);

    localparam int CD_W = $clog2(COOLDOWN + 1);

    logic [CD_W-1:0] cnt [NUM_STOCKS];

    // Reload on commit, otherwise count down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STOCKS; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_STOCKS; i++) begin
                if (load && load_id == ID_W'(i))
                    cnt[i] <= CD_W'(COOLDOWN);
                else if (cnt[i] != '0)
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    // Zero flag per stock gates trading.
    always_comb begin
        zero = '0;
        for (int i = 0; i < NUM_STOCKS; i++)
            zero[i] = (cnt[i] == '0);
    end

endmodule

// File: rtl/rsi_order_manager.sv
// Turns RSI buy/sell decisions into checked trade orders.
// Owns cash, positions and the order FSM.
module rsi_order_manager
    import rsi_trade_pkg::*;
#(
    parameter logic [CASH_W-1:0] CASH_INIT = 16'd1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sig_valid,
    input  logic               buy_signal,
    input  logic               sell_signal,
    input  logic [ID_W-1:0]    stock_id,
    input  logic [PRICE_W-1:0] price,
    rsi_order_manager_if.master ord,
    output logic [CASH_W-1:0]  cash_out,
    input  logic [ID_W-1:0]    pos_query_id,
    output logic [POS_W-1:0]   pos_query,
    output logic [7:0]         reject_cnt,
    output logic [7:0]         drop_cnt,
    output logic               busy
);

    state_t             state;
    state_t             state_nx;
    logic               latch;
    logic               reject;
    logic               fire;
    logic               side_q;
    logic [ID_W-1:0]    id_q;
    logic [PRICE_W-1:0] price_q;
    logic [CASH_W-1:0]  cash;
    logic [POS_W-1:0]   pos [NUM_STOCKS];
    logic [NUM_STOCKS-1:0] cd_zero;

    logic               req;
    logic [COST_W-1:0]  cost_n;
    logic [CASH_W-1:0]  cost;
    logic [POS_W-1:0]   pos_sel;
    logic [POS_W:0]     pos_plus;
    logic [CASH_W:0]    cash_sum;
    logic               buy_ok;
    logic               sell_ok;
    logic               pass;

    assign req      = sig_valid & (buy_signal ^ sell_signal);
    assign cost_n   = COST_W'(price_q) * COST_W'(LOT_SIZE);
    assign cost     = CASH_W'(cost_n);
    assign pos_sel  = pos[id_q];
    assign pos_plus = {1'b0, pos_sel} + (POS_W+1)'(LOT_SIZE);
    assign cash_sum = {1'b0, cash} + {1'b0, cost};
    assign buy_ok   = cd_zero[id_q] && (cash >= cost)
                   && (pos_plus <= (POS_W+1)'(MAX_POS));
    assign sell_ok  = cd_zero[id_q] && (pos_sel >= POS_W'(LOT_SIZE));
    assign pass     = (side_q == SIDE_BUY) ? buy_ok : sell_ok;
    assign fire     = (state == ISSUE) && ord.order_ready;

    assign ord.order_valid = (state == ISSUE);
    assign ord.order_side  = side_q;
    assign ord.order_stock = id_q;
    assign ord.order_price = price_q;
    assign ord.order_qty   = POS_W'(LOT_SIZE);

    assign cash_out  = cash;
    assign pos_query = pos[pos_query_id];
    assign busy      = (state != IDLE);

    rsi_cooldown_bank u_cd (
        .clk     (clk),
        .rst     (rst),
        .load    (fire),
        .load_id (id_q),
        .zero    (cd_zero)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state, latch strobe and reject strobe.
    always_comb begin
        state_nx = state;
        latch    = 1'b0;
        reject   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nx = CHECK;
                    latch    = 1'b1;
                end
            end
            CHECK: begin
                state_nx = pass ? ISSUE : IDLE;
                reject   = !pass;
            end
            ISSUE: begin
                if (ord.order_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Capture the request so the order fields stay stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            side_q  <= 1'b0;
            id_q    <= '0;
            price_q <= '0;
        end else if (latch) begin
            side_q  <= buy_signal;
            id_q    <= stock_id;
            price_q <= price;
        end
    end

    // Commit cash and position on the accepted handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cash <= CASH_INIT;
            for (int i = 0; i < NUM_STOCKS; i++)
                pos[i] <= '0;
        end else if (fire) begin
            if (side_q == SIDE_BUY) begin
                cash     <= cash - cost;
                pos[id_q] <= pos_sel + POS_W'(LOT_SIZE);
            end else begin
                cash     <= cash_sum[CASH_W] ? '1 : cash_sum[CASH_W-1:0];
                pos[id_q] <= pos_sel - POS_W'(LOT_SIZE);
            end
        end
    end

    // Saturating reject and drop counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reject_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if (reject && reject_cnt != 8'hFF)
                reject_cnt <= reject_cnt + 8'd1;
            if (req && state != IDLE && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule
